// File: rtl/hood_tk_if.sv
// Bundle of control, status and display signals between the range-hood
// controller and its timekeeping core.
interface hood_tk_if #(
   parameter int NUM_CD = 2
);
   logic                  tick_o;
   logic                  tod_load;
   logic [23:0]           tod_value_i;
   logic [23:0]           tod_o;
   logic                  run_en;
   logic                  wt_clr;
   logic [23:0]           worktime_o;
   logic [23:0]           remind_i;
   logic                  remind_ack;
   logic                  remind_o;
   logic [NUM_CD-1:0]     cd_load;
   logic [24*NUM_CD-1:0]  cd_value_i;
   logic [NUM_CD-1:0]     cd_abort;
   logic [24*NUM_CD-1:0]  cd_o;
   logic [NUM_CD-1:0]     cd_busy;
   logic [NUM_CD-1:0]     cd_done;

   modport slave (
      input  tod_load, tod_value_i, run_en, wt_clr, remind_i, remind_ack,
             cd_load, cd_value_i, cd_abort,
      output tick_o, tod_o, worktime_o, remind_o, cd_o, cd_busy, cd_done
   );

   modport master (
      output tod_load, tod_value_i, run_en, wt_clr, remind_i, remind_ack,
             cd_load, cd_value_i, cd_abort,
      input  tick_o, tod_o, worktime_o, remind_o, cd_o, cd_busy, cd_done
   );
endinterface

// File: rtl/hood_timekeeper.sv
// 1 Hz timebase with BCD time of day, work-time accumulator with sticky
// reminder, and NUM_CD independent BCD countdown channels.
module hood_timekeeper #(
   parameter int CLK_FREQ = 100000000,
   parameter int NUM_CD   = 2,
   parameter int WT_SAT   = 1
) (
   input  logic       clk,
   input  logic       rst,
   hood_tk_if.slave   bus
);
   localparam int             CW      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_FREQ - 1);

   // BCD +1 s on HHMMSS; hours wrap to 00 after reaching hmax.
   function automatic logic [23:0] bcd_inc(input logic [23:0] v, input logic [7:0] hmax);
      logic [23:0] r;
      r = v;
      if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
      else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd5) r[7:4] = v[7:4] + 4'd1;
         else begin
            r[7:4] = 4'd0;
            if (v[11:8] != 4'd9) r[11:8] = v[11:8] + 4'd1;
            else begin
               r[11:8] = 4'd0;
               if (v[15:12] != 4'd5) r[15:12] = v[15:12] + 4'd1;
               else begin
                  r[15:12] = 4'd0;
                  if (v[23:16] == hmax) r[23:16] = 8'h00;
                  else if (v[19:16] != 4'd9) r[19:16] = v[19:16] + 4'd1;
                  else begin
                     r[19:16] = 4'd0;
                     r[23:20] = v[23:20] + 4'd1;
                  end
               end
            end
         end
      end
      return r;
   endfunction

   // BCD -1 s; only applied to nonzero values, so the borrow never runs past the hours.
   function automatic logic [23:0] bcd_dec(input logic [23:0] v);
      logic [23:0] r;
      r = v;
      if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
      else begin
         r[3:0] = 4'd9;
         if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
         else begin
            r[7:4] = 4'd5;
            if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
            else begin
               r[11:8] = 4'd9;
               if (v[15:12] != 4'd0) r[15:12] = v[15:12] - 4'd1;
               else begin
                  r[15:12] = 4'd5;
                  if (v[19:16] != 4'd0) r[19:16] = v[19:16] - 4'd1;
                  else begin
                     r[19:16] = 4'd9;
                     r[23:20] = v[23:20] - 4'd1;
                  end
               end
            end
         end
      end
      return r;
   endfunction

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic [23:0]   tod_q, tod_d;
   logic [23:0]   wt_q, wt_d;
   logic          remind_q, remind_d;
   logic          tick_now;
   logic [23:0]   wt_inc;
   logic          remind_set;

   assign tick_now = (cnt_q == CNT_MAX);
   assign wt_inc   = (WT_SAT != 0 && wt_q == 24'h995959) ? wt_q : bcd_inc(wt_q, 8'h99);

   always_comb begin
      cnt_d      = (bus.tod_load || tick_now) ? '0 : cnt_q + 1'b1;
      tick_d     = tick_now;
      tod_d      = tod_q;
      wt_d       = wt_q;
      remind_d   = remind_q;
      remind_set = 1'b0;
      if (bus.tod_load)  tod_d = bus.tod_value_i;
      else if (tick_now) tod_d = bcd_inc(tod_q, 8'h23);
      if (bus.wt_clr) begin
         wt_d     = '0;
         remind_d = 1'b0;
      end else begin
         if (tick_now && bus.run_en) begin
            wt_d       = wt_inc;
            remind_set = (wt_inc == bus.remind_i) && (bus.remind_i != 24'h0);
         end
         // A fresh match beats a same-cycle acknowledge.
         if (remind_set)          remind_d = 1'b1;
         else if (bus.remind_ack) remind_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         tick_q   <= 1'b0;
         tod_q    <= '0;
         wt_q     <= '0;
         remind_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         tod_q    <= tod_d;
         wt_q     <= wt_d;
         remind_q <= remind_d;
      end
   end

   assign bus.tick_o     = tick_q;
   assign bus.tod_o      = tod_q;
   assign bus.worktime_o = wt_q;
   assign bus.remind_o   = remind_q;

   logic [24*NUM_CD-1:0] cd_vec;
   logic [NUM_CD-1:0]    busy_vec;
   logic [NUM_CD-1:0]    done_vec;

   for (genvar gi = 0; gi < NUM_CD; gi++) begin : g_cd
      logic [23:0] cd_q, cd_d;
      logic        busy_q, busy_d;
      logic        done_q, done_d;
      logic [23:0] cd_dec;

      assign cd_dec = bcd_dec(cd_q);

      always_comb begin
         cd_d   = cd_q;
         busy_d = busy_q;
         done_d = 1'b0;
         if (bus.cd_abort[gi]) begin
            cd_d   = '0;
            busy_d = 1'b0;
         end else if (bus.cd_load[gi]) begin
            cd_d   = bus.cd_value_i[24*gi +: 24];
            busy_d = (bus.cd_value_i[24*gi +: 24] != 24'h0);
         end else if (tick_now && busy_q) begin
            cd_d = cd_dec;
            if (cd_dec == 24'h0) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cd_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
         end else begin
            cd_q   <= cd_d;
            busy_q <= busy_d;
            done_q <= done_d;
         end
      end

      assign cd_vec[24*gi +: 24] = cd_q;
      assign busy_vec[gi]        = busy_q;
      assign done_vec[gi]        = done_q;
   end

   assign bus.cd_o    = cd_vec;
   assign bus.cd_busy = busy_vec;
   assign bus.cd_done = done_vec;
endmodule

// File: tb/tb_hood_timekeeper.sv
// Bench for hood_timekeeper: directed scenarios plus random traffic, every
// cycle compared against a seconds-based reference model.
module tb_hood_timekeeper;
   localparam int CF  = 4;
   localparam int NC  = 2;
   localparam int SAT = 1;
   localparam int WT_MAX = 99*3600 + 59*60 + 59;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hood_tk_if #(.NUM_CD(NC)) bus ();

   hood_timekeeper #(.CLK_FREQ(CF), .NUM_CD(NC), .WT_SAT(SAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference state in plain seconds.
   int m_cnt;
   bit m_tick;
   int m_tod;
   int m_wt;
   bit m_rem;
   int m_cd   [NC];
   bit m_busy [NC];
   bit m_done [NC];

   function automatic logic [23:0] to_bcd(int s);
      int h, m, sec;
      h = s / 3600; m = (s / 60) % 60; sec = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
   endfunction

   function automatic int from_bcd(logic [23:0] b);
      return (int'(b[23:20]) * 10 + int'(b[19:16])) * 3600
           + (int'(b[15:12]) * 10 + int'(b[11:8])) * 60
           +  int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_tick = 0; m_tod = 0; m_wt = 0; m_rem = 0;
      for (int k = 0; k < NC; k++) begin
         m_cd[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      end
   endtask

   task automatic model_edge();
      bit t, set;
      t      = (m_cnt == CF - 1);
      m_cnt  = (bus.tod_load || t) ? 0 : m_cnt + 1;
      m_tick = t;
      if (bus.tod_load) m_tod = from_bcd(bus.tod_value_i);
      else if (t)       m_tod = (m_tod + 1) % 86400;
      if (bus.wt_clr) begin
         m_wt = 0; m_rem = 0;
      end else begin
         set = 0;
         if (t && bus.run_en) begin
            if (m_wt == WT_MAX) m_wt = (SAT != 0) ? m_wt : 0;
            else                m_wt = m_wt + 1;
            set = (to_bcd(m_wt) == bus.remind_i) && (bus.remind_i != 24'h0);
         end
         if (set)                 m_rem = 1;
         else if (bus.remind_ack) m_rem = 0;
      end
      for (int k = 0; k < NC; k++) begin
         m_done[k] = 0;
         if (bus.cd_abort[k]) begin
            m_cd[k] = 0; m_busy[k] = 0;
         end else if (bus.cd_load[k]) begin
            m_cd[k]   = from_bcd(bus.cd_value_i[24*k +: 24]);
            m_busy[k] = (m_cd[k] != 0);
         end else if (t && m_busy[k]) begin
            m_cd[k] = m_cd[k] - 1;
            if (m_cd[k] == 0) begin
               m_busy[k] = 0; m_done[k] = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      check("tick", bus.tick_o, m_tick);
      check("tod", bus.tod_o, to_bcd(m_tod));
      check("wt", bus.worktime_o, to_bcd(m_wt));
      check("remind", bus.remind_o, m_rem);
      for (int k = 0; k < NC; k++) begin
         check($sformatf("cd%0d", k), bus.cd_o[24*k +: 24], to_bcd(m_cd[k]));
         check($sformatf("busy%0d", k), bus.cd_busy[k], m_busy[k]);
         check($sformatf("done%0d", k), bus.cd_done[k], m_done[k]);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         if (!rst) model_reset();
         else      model_edge();
         #1;
         check_all();
      end
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         cyc(1);
         n++;
      end while (!bus.tick_o && n < CF + 2);
      if (!bus.tick_o) check("tick_wait", 0, 1);
   endtask

   task automatic idle_inputs();
      bus.tod_load = 0; bus.tod_value_i = '0; bus.run_en = 0; bus.wt_clr = 0;
      bus.remind_i = '0; bus.remind_ack = 0; bus.cd_load = '0;
      bus.cd_value_i = '0; bus.cd_abort = '0;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      #12;
      check_all();
      @(negedge clk) rst = 1'b1;
      cyc(3);
      check("tick_pre", bus.tick_o, 0);
      cyc(1);
      check("first_tick", bus.tick_o, 1);
      check("first_tod", bus.tod_o, 24'h000001);
      $display("txn reset release: first tick seen");
      cyc(6);
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      check("rst_tod", bus.tod_o, 24'h0);
      @(negedge clk) rst = 1'b1;
      $display("txn async reset mid-count");

      bus.tod_load = 1; bus.tod_value_i = 24'h235959;
      cyc(1);
      bus.tod_load = 0;
      wait_tick();
      check("tod_midnight", bus.tod_o, 24'h000000);
      bus.tod_load = 1; bus.tod_value_i = 24'h095959;
      cyc(1);
      bus.tod_load = 0;
      wait_tick();
      check("tod_hour", bus.tod_o, 24'h100000);
      while (m_cnt != CF - 1) cyc(1);
      bus.tod_load = 1; bus.tod_value_i = 24'h123456;
      cyc(1);
      bus.tod_load = 0;
      check("tod_coinc", bus.tod_o, 24'h123456);
      cyc(CF - 1);
      check("tick_restart_gap", bus.tick_o, 0);
      cyc(1);
      check("tick_restart", bus.tick_o, 1);
      check("tod_after_coinc", bus.tod_o, 24'h123457);
      $display("txn tod load/rollover/coincident");

      bus.wt_clr = 1;
      cyc(1);
      bus.wt_clr = 0; bus.remind_i = 24'h000003; bus.run_en = 1;
      repeat (3) wait_tick();
      check("wt3", bus.worktime_o, 24'h000003);
      check("rem_set", bus.remind_o, 1);
      repeat (2) wait_tick();
      check("rem_sticky", bus.remind_o, 1);
      bus.remind_ack = 1;
      cyc(1);
      bus.remind_ack = 0;
      check("rem_ack", bus.remind_o, 0);
      bus.run_en = 0;
      repeat (2) wait_tick();
      check("wt_hold", bus.worktime_o, 24'h000005);
      $display("txn work time and reminder");

      bus.cd_load = 2'b11; bus.cd_value_i = {24'h000003, 24'h000100};
      cyc(1);
      bus.cd_load = '0;
      wait_tick();
      check("cd0_borrow", bus.cd_o[23:0], 24'h000059);
      repeat (2) wait_tick();
      check("cd1_zero", bus.cd_o[47:24], 24'h0);
      check("cd1_done", bus.cd_done[1], 1);
      check("cd1_idle", bus.cd_busy[1], 0);
      cyc(1);
      check("cd1_done_once", bus.cd_done[1], 0);
      repeat (57) wait_tick();
      check("cd0_done", bus.cd_done[0], 1);
      $display("txn countdown borrow and expiry");

      bus.cd_load = 2'b01; bus.cd_value_i = '0;
      cyc(1);
      bus.cd_load = '0;
      check("cd0_zero_idle", bus.cd_busy[0], 0);
      bus.cd_load = 2'b10; bus.cd_value_i = {24'h000005, 24'h0};
      cyc(1);
      bus.cd_load = '0;
      repeat (3) wait_tick();
      check("cd1_at2", bus.cd_o[47:24], 24'h000002);
      bus.cd_abort = 2'b10;
      cyc(1);
      bus.cd_abort = '0;
      check("cd1_abort", bus.cd_o[47:24], 24'h0);
      check("cd1_abort_busy", bus.cd_busy[1], 0);
      wait_tick();
      check("cd1_abort_nodone", bus.cd_done[1], 0);
      bus.cd_abort = 2'b10; bus.cd_load = 2'b10; bus.cd_value_i = {24'h000010, 24'h0};
      cyc(1);
      bus.cd_abort = '0; bus.cd_load = '0;
      check("abort_wins", bus.cd_busy[1], 0);
      bus.cd_load = 2'b01; bus.cd_value_i = {24'h0, 24'h000030};
      cyc(1);
      bus.cd_load = '0;
      wait_tick();
      bus.cd_load = 2'b01; bus.cd_value_i = {24'h0, 24'h000045};
      cyc(1);
      bus.cd_load = '0;
      check("cd0_reload", bus.cd_o[23:0], 24'h000045);
      $display("txn countdown zero/abort/reload");

      for (int i = 0; i < 3000; i++) begin
         bus.tod_load    = ($urandom_range(0, 99) == 0);
         bus.tod_value_i = to_bcd($urandom_range(0, 86399));
         bus.run_en      = ($urandom_range(0, 3) != 0);
         bus.wt_clr      = ($urandom_range(0, 299) == 0);
         bus.remind_ack  = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 199) == 0) bus.remind_i = to_bcd($urandom_range(0, 60));
         for (int k = 0; k < NC; k++) begin
            bus.cd_load[k]  = ($urandom_range(0, 39) == 0);
            bus.cd_abort[k] = ($urandom_range(0, 149) == 0);
            bus.cd_value_i[24*k +: 24] = to_bcd($urandom_range(0, 40));
         end
         cyc(1);
      end
      idle_inputs();
      cyc(4);
      $display("txn random traffic: 3000 cycles");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
